// File: rtl/axis_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_rx_frame_buffer
//  Description : AXI-Stream slave that captures one frame (ending on TLAST,
//                or cut short when the FIFO fills) and replays the stored
//                words through a valid/ready read port on a start_read pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_rx_frame_buffer #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int DEPTH                = 16
) (
    input  logic                              s_axis_aclk,
    input  logic                              s_axis_areset,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] s_axis_tstrb,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    input  logic                              start_read,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   rd_data,
    output logic                              rd_last,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic                              frame_done,
    output logic                              frame_trunc,
    output logic [$clog2(DEPTH):0]            word_count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;
    localparam int c_sw = C_S_AXIS_TDATA_WIDTH / 8;

    localparam logic [c_cw-1:0] c_one       = c_cw'(1);
    localparam logic [c_cw-1:0] c_two       = c_cw'(2);
    localparam logic [c_cw-1:0] c_depth_m1  = c_cw'(DEPTH - 1);

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_recv  = 2'd1;
    localparam logic [1:0] c_hold  = 2'd2;
    localparam logic [1:0] c_drain = 2'd3;

    logic [1:0]                        r_state;
    logic [1:0]                        w_next_state;
    logic [c_aw-1:0]                   r_wr_ptr;
    logic [c_aw-1:0]                   r_rd_ptr;
    logic [c_aw-1:0]                   w_rd_ptr_nxt;
    logic [c_cw-1:0]                   r_count;
    logic                              r_tready;
    logic                              r_rd_valid;
    logic                              r_rd_last;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   r_rd_data;
    logic                              r_frame_done;
    logic                              r_frame_trunc;
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   r_mem [DEPTH];
    logic [C_S_AXIS_TDATA_WIDTH-1:0]   w_wr_data;
    logic                              w_wr_fire;
    logic                              w_rd_fire;
    logic                              w_last_rd;

    assign w_wr_fire    = s_axis_tvalid & r_tready;
    assign w_rd_fire    = r_rd_valid & rd_ready;
    assign w_last_rd    = w_rd_fire & (r_count == c_one);
    assign w_rd_ptr_nxt = r_rd_ptr + 1'b1;

    // Byte lanes with a low strobe are stored as zero.
    genvar gi;
    generate
        for (gi = 0; gi < c_sw; gi++) begin : g_strb
            assign w_wr_data[gi*8 +: 8] = s_axis_tstrb[gi] ? s_axis_tdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    // State register.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: receive until TLAST or full, hold, then drain.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (s_axis_tvalid) w_next_state = c_recv;
            c_recv:  if (w_wr_fire && (s_axis_tlast || (r_count == c_depth_m1)))
                         w_next_state = c_hold;
            c_hold:  if (start_read) w_next_state = c_drain;
            c_drain: if (w_last_rd) w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    // Storage array; stale contents are harmless because pointers reset.
    always_ff @(posedge s_axis_aclk) begin
        if (w_wr_fire) begin
            r_mem[r_wr_ptr] <= w_wr_data;
        end
    end

    // Pointers, occupancy, handshake and status registers.
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_tready      <= 1'b0;
            r_rd_valid    <= 1'b0;
            r_rd_last     <= 1'b0;
            r_rd_data     <= '0;
            r_frame_done  <= 1'b0;
            r_frame_trunc <= 1'b0;
        end else begin
            // Leaving RECV always coincides with the full or TLAST beat,
            // so tready is never high while the FIFO is full.
            r_tready <= (w_next_state == c_recv);

            if (w_wr_fire) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_fire) r_rd_ptr <= w_rd_ptr_nxt;

            case ({w_wr_fire, w_rd_fire})
                2'b10:   r_count <= r_count + c_one;
                2'b01:   r_count <= r_count - c_one;
                default: r_count <= r_count;
            endcase

            if ((r_state == c_recv) && (w_next_state == c_hold)) begin
                r_frame_done  <= 1'b1;
                r_frame_trunc <= ~s_axis_tlast;
            end

            if ((r_state == c_hold) && start_read) begin
                r_rd_valid <= 1'b1;
                r_rd_data  <= r_mem[r_rd_ptr];
                r_rd_last  <= (r_count == c_one);
            end else if (w_rd_fire) begin
                if (w_last_rd) begin
                    r_rd_valid    <= 1'b0;
                    r_rd_last     <= 1'b0;
                    r_frame_done  <= 1'b0;
                    r_frame_trunc <= 1'b0;
                end else begin
                    r_rd_data <= r_mem[w_rd_ptr_nxt];
                    r_rd_last <= (r_count == c_two);
                end
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign rd_data       = r_rd_data;
    assign rd_last       = r_rd_last;
    assign rd_valid      = r_rd_valid;
    assign frame_done    = r_frame_done;
    assign frame_trunc   = r_frame_trunc;
    assign word_count    = r_count;

endmodule
`default_nettype wire

// File: tb/tb_axis_rx_frame_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_rx_frame_buffer
//  Description : Scoreboard bench for axis_rx_frame_buffer (frame capture,
//                truncation, strobe masking, read stalls, reset mid-drain).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_rx_frame_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tstrb = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        start_read = 1'b0;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic        frame_done;
    logic        frame_trunc;
    logic [4:0]  word_count;

    int tests = 0;
    int fails = 0;
    logic [31:0] q[$];

    always #5 clk = ~clk;

    axis_rx_frame_buffer #(.C_S_AXIS_TDATA_WIDTH(32), .DEPTH(16)) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .s_axis_tdata  (tdata),
        .s_axis_tstrb  (tstrb),
        .s_axis_tlast  (tlast),
        .s_axis_tvalid (tvalid),
        .s_axis_tready (tready),
        .start_read    (start_read),
        .rd_data       (rd_data),
        .rd_last       (rd_last),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .frame_done    (frame_done),
        .frame_trunc   (frame_trunc),
        .word_count    (word_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
        return m;
    endfunction

    // Offer one beat until accepted or the bound expires; accepted beats
    // go onto the scoreboard in their masked form.
    task automatic send_beat(input logic [31:0] d, input logic [3:0] s, input logic l,
                             input int bound, output bit ok);
        bit acc;
        ok = 0;
        tdata = d; tstrb = s; tlast = l; tvalid = 1'b1;
        for (int c = 0; c < bound && !ok; c++) begin
            acc = tready;
            tick();
            if (acc) begin
                ok = 1;
                q.push_back(mask(d, s));
            end
        end
        tvalid = 1'b0; tlast = 1'b0;
    endtask

    // Pulse start_read and pop up to max_words from the DUT, checking data,
    // rd_last and stall stability against the scoreboard.
    task automatic drain(input int max_words, input bit stall, output int got);
        bit          pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int          cyc = 0;
        int          k = 0;
        bit          was_stall = 0;
        logic [31:0] held = '0;
        logic [31:0] exp;
        logic        exp_last;
        got = 0;
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        tests++;
        if (rd_valid !== 1'b1) begin
            fails++; $display("FAIL first_valid: got %b expected 1", rd_valid);
        end
        while (got < max_words && cyc < 200) begin
            rd_ready = stall ? pat[k % 4] : 1'b1;
            k++;
            if (was_stall) begin
                tests++;
                if (rd_valid !== 1'b1 || rd_data !== held) begin
                    fails++;
                    $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=%h", rd_valid, rd_data, held);
                end
            end
            if (rd_valid && rd_ready) begin
                exp = q.pop_front();
                exp_last = (q.size() == 0);
                tests++;
                if (rd_data !== exp) begin
                    fails++; $display("FAIL rd_data: got %h expected %h", rd_data, exp);
                end
                tests++;
                if (rd_last !== exp_last) begin
                    fails++; $display("FAIL rd_last: got %b expected %b (word %h)", rd_last, exp_last, exp);
                end
                got++;
                was_stall = 0;
            end else begin
                was_stall = rd_valid;
                held = rd_data;
            end
            tick();
            cyc++;
        end
        rd_ready = 1'b0;
        if (got < max_words) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d words expected %0d", got, max_words);
        end
    endtask

    task automatic check_idle_after_drain(input string tag);
        tests++;
        if (rd_valid !== 1'b0 || frame_done !== 1'b0 || frame_trunc !== 1'b0 || word_count !== 5'd0) begin
            fails++;
            $display("FAIL %s_idle: got v=%b done=%b trunc=%b cnt=%0d expected 0 0 0 0",
                     tag, rd_valid, frame_done, frame_trunc, word_count);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (tready !== 1'b0 || rd_valid !== 1'b0 || rd_last !== 1'b0 || rd_data !== 32'h0 ||
            frame_done !== 1'b0 || frame_trunc !== 1'b0 || word_count !== 5'd0) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b v=%b l=%b d=%h done=%b trunc=%b cnt=%0d expected all 0",
                     tready, rd_valid, rd_last, rd_data, frame_done, frame_trunc, word_count);
        end
    endtask

    task automatic test_basic_frame();
        bit ok;
        int acc = 0;
        int got;
        logic [31:0] w;
        for (int i = 1; i <= 4; i++) begin
            w = 32'h1111_1111 * i;
            send_beat(w, 4'hF, (i == 4), 4, ok);
            if (ok) acc++;
        end
        tests++;
        if (acc !== 4) begin fails++; $display("FAIL basic_accepted: got %0d expected 4", acc); end
        tests++;
        if (word_count !== 5'd4 || frame_done !== 1'b1 || frame_trunc !== 1'b0 || tready !== 1'b0) begin
            fails++;
            $display("FAIL basic_status: got cnt=%0d done=%b trunc=%b rdy=%b expected 4 1 0 0",
                     word_count, frame_done, frame_trunc, tready);
        end
        drain(4, 0, got);
        check_idle_after_drain("basic");
    endtask

    task automatic test_truncation();
        bit ok;
        int acc = 0;
        int got;
        for (int i = 1; i <= 20; i++) begin
            send_beat(32'hC000_0000 + i, 4'hF, 1'b0, 3, ok);
            if (ok) acc++;
        end
        tests++;
        if (acc !== 16) begin fails++; $display("FAIL trunc_accepted: got %0d expected 16", acc); end
        tests++;
        if (word_count !== 5'd16 || frame_done !== 1'b1 || frame_trunc !== 1'b1 || tready !== 1'b0) begin
            fails++;
            $display("FAIL trunc_status: got cnt=%0d done=%b trunc=%b rdy=%b expected 16 1 1 0",
                     word_count, frame_done, frame_trunc, tready);
        end
        drain(16, 0, got);
        check_idle_after_drain("trunc");
    endtask

    task automatic test_strobe();
        bit ok;
        int got;
        send_beat(32'hAABB_CCDD, 4'h5, 1'b1, 4, ok);
        tests++;
        if (!ok || q.size() != 1 || q[0] !== 32'h00BB_00DD) begin
            fails++; $display("FAIL strobe_accept: got ok=%b expected accepted beat 00bb00dd", ok);
        end
        drain(1, 0, got);
        check_idle_after_drain("strobe");
    endtask

    task automatic test_stall();
        bit ok;
        int got;
        send_beat(32'h0000_A001, 4'hF, 1'b0, 4, ok);
        start_read = 1'b1;
        tick();
        start_read = 1'b0;
        tick();
        tests++;
        if (rd_valid !== 1'b0) begin
            fails++; $display("FAIL start_in_recv: got rd_valid=%b expected 0", rd_valid);
        end
        for (int i = 2; i <= 4; i++) send_beat(32'h0000_A000 + i, 4'hF, (i == 4), 4, ok);
        tests++;
        if (word_count !== 5'd4 || frame_done !== 1'b1 || rd_valid !== 1'b0) begin
            fails++;
            $display("FAIL stall_frame: got cnt=%0d done=%b v=%b expected 4 1 0", word_count, frame_done, rd_valid);
        end
        drain(4, 1, got);
        check_idle_after_drain("stall");
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        int got;
        for (int i = 1; i <= 4; i++) send_beat(32'hD000_0000 + i, 4'hF, (i == 4), 4, ok);
        drain(2, 0, got);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        q.delete();
        tests++;
        if (rd_valid !== 1'b0 || word_count !== 5'd0 || frame_done !== 1'b0 || tready !== 1'b0) begin
            fails++;
            $display("FAIL mid_drain_reset: got v=%b cnt=%0d done=%b rdy=%b expected 0 0 0 0",
                     rd_valid, word_count, frame_done, tready);
        end
        send_beat(32'hE000_0001, 4'hF, 1'b0, 4, ok);
        send_beat(32'hE000_0002, 4'hF, 1'b1, 4, ok);
        tests++;
        if (word_count !== 5'd2 || frame_done !== 1'b1) begin
            fails++; $display("FAIL post_reset_frame: got cnt=%0d done=%b expected 2 1", word_count, frame_done);
        end
        drain(2, 0, got);
        check_idle_after_drain("post_reset");
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        tick();
        test_reset();
        test_basic_frame();
        test_truncation();
        test_strobe();
        test_stall();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
